// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low two address bits are dropped.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular fetch buffer: entries are allocated when a request is accepted,
// filled in order as responses return, and popped in order by decode.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     allocEn,
  input  logic [31:0]              allocPc,
  input  logic                     fillEn,
  input  logic [31:0]              fillData,
  input  logic                     popEn,
  output logic                     full,
  output logic                     hasUnfilled,
  output logic [$clog2(DEPTH):0]   unfilledCnt,
  output logic                     headValid,
  output logic [31:0]              headPc,
  output logic [31:0]              headInstr
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] allocPtr;
  logic [PW-1:0] fillPtr;
  logic [PW-1:0] popPtr;
  logic [PW-1:0] usedCnt;
  fetch_entry_t  headEntry;

  // The extra pointer bit distinguishes a full buffer from an empty one.
  assign usedCnt     = allocPtr - popPtr;
  assign full        = (usedCnt == PW'(DEPTH));
  assign unfilledCnt = allocPtr - fillPtr;
  assign hasUnfilled = (allocPtr != fillPtr);
  assign headEntry   = entries[popPtr[IW-1:0]];
  assign headValid   = (allocPtr != popPtr) && headEntry.filled;
  assign headPc      = headEntry.pc;
  assign headInstr   = headEntry.instr;

  // Pointer and entry update; a flush simply rewinds all three pointers, which
  // makes every entry unallocated regardless of its stale contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      allocPtr <= '0;
      fillPtr  <= '0;
      popPtr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      allocPtr <= '0;
      fillPtr  <= '0;
      popPtr   <= '0;
    end else begin
      if (allocEn) begin
        entries[allocPtr[IW-1:0]] <= '{pc: allocPc, instr: INSTR_NOP, filled: 1'b0};
        allocPtr <= allocPtr + PW'(1);
      end
      if (fillEn) begin
        entries[fillPtr[IW-1:0]].instr  <= fillData;
        entries[fillPtr[IW-1:0]].filled <= 1'b1;
        fillPtr <= fillPtr + PW'(1);
      end
      if (popEn) begin
        popPtr <= popPtr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests,
// discards wrong-path responses after a redirect and feeds decode from a queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  // Wide enough for back-to-back redirects while earlier drops are still pending.
  localparam int DW = $clog2(DEPTH) + 3;

  logic [31:0]            fetchPc;
  logic                   fetchEn;
  logic [DW-1:0]          dropCnt;
  logic [DW-1:0]          dropNext;
  logic                   queueFull;
  logic                   hasUnfilled;
  logic [$clog2(DEPTH):0] unfilledCnt;
  logic                   headValid;
  logic [31:0]            headPc;
  logic [31:0]            headInstr;
  logic                   reqAccept;
  logic                   rspFill;
  logic                   popEn;
  logic                   anyOutstanding;

  // fetchEn keeps the request channel quiet while in reset without a path from resetn.
  assign mem_req_valid  = fetchEn && !queueFull;
  assign mem_req_addr   = fetchPc;
  assign reqAccept      = mem_req_valid && mem_req_ready;
  assign anyOutstanding = (dropCnt != '0) || hasUnfilled;
  assign rspFill        = mem_rsp_valid && (dropCnt == '0) && hasUnfilled && !redirect_valid;
  assign popEn          = headValid && instr_ready && !redirect_valid;

  assign instr_valid = headValid;
  assign instr       = headValid ? headInstr : INSTR_NOP;
  assign instr_pc    = headValid ? headPc : 32'h0;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) queue (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (redirect_valid),
    .allocEn     (reqAccept && !redirect_valid),
    .allocPc     (fetchPc),
    .fillEn      (rspFill),
    .fillData    (mem_rsp_data),
    .popEn       (popEn),
    .full        (queueFull),
    .hasUnfilled (hasUnfilled),
    .unfilledCnt (unfilledCnt),
    .headValid   (headValid),
    .headPc      (headPc),
    .headInstr   (headInstr)
  );

  // On redirect every request still owed a response becomes a drop, counting
  // this cycle's accept and crediting a response that lands this cycle.
  always_comb begin
    dropNext = dropCnt;
    if (redirect_valid) begin
      dropNext = dropCnt + DW'(unfilledCnt) + DW'(reqAccept);
      if (mem_rsp_valid && anyOutstanding) begin
        dropNext = dropNext - DW'(1);
      end
    end else if (mem_rsp_valid && (dropCnt != '0)) begin
      dropNext = dropCnt - DW'(1);
    end
  end

  // Fetch PC, drop counter and request enable; redirect takes priority over advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetchPc <= RESET_ADDR;
      dropCnt <= '0;
      fetchEn <= 1'b0;
    end else begin
      fetchEn <= 1'b1;
      dropCnt <= dropNext;
      if (redirect_valid) begin
        fetchPc <= alignWord(redirect_pc);
      end else if (reqAccept) begin
        fetchPc <= fetchPc + 32'd4;
      end
    end
  end

endmodule
